// File: rtl/imm_narrow_pkg.sv
// Shared definitions for the immediate narrowing unit: default widths,
// skid-buffer state encoding and the narrowing function.
package imm_narrow_pkg;

  localparam int IN_W_DEF  = 8;
  localparam int OUT_W_DEF = 3;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  // Packed so that {fit, field} is directly usable as a buffer payload.
  typedef struct packed {
    logic                 fit;
    logic [OUT_W_DEF-1:0] field;
  } narrow_t;

  // Narrow a signed IN_W_DEF value to OUT_W_DEF bits. The value fits when
  // every bit from the top down to the field's sign bit agrees, which is
  // exactly the condition for sign extension to round-trip.
  function automatic narrow_t narrow(input logic [IN_W_DEF-1:0] value,
                                     input logic                sat);
    narrow_t                        res;
    logic [IN_W_DEF-OUT_W_DEF:0]    hi;
    hi      = value[IN_W_DEF-1:OUT_W_DEF-1];
    res.fit = (hi == {(IN_W_DEF-OUT_W_DEF+1){1'b0}}) ||
              (hi == {(IN_W_DEF-OUT_W_DEF+1){1'b1}});
    if (res.fit || !sat) begin
      res.field = value[OUT_W_DEF-1:0];
    end else if (value[IN_W_DEF-1]) begin
      res.field = {1'b1, {(OUT_W_DEF-1){1'b0}}};
    end else begin
      res.field = {1'b0, {(OUT_W_DEF-1){1'b1}}};
    end
    return res;
  endfunction

endpackage

// File: rtl/imm_narrow_unit_skid.sv
// Two-entry valid/ready skid buffer. The main register drives the output;
// the skid register catches the one word accepted on the first stalled cycle.
module narrow_skid_buf
  import imm_narrow_pkg::*;
#(
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_payload,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_payload
);

  localparam logic [1:0] ST_EMPTY = BUF_EMPTY;
  localparam logic [1:0] ST_ONE   = BUF_ONE;
  localparam logic [1:0] ST_TWO   = BUF_TWO;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] main_q, main_d;
  logic [PW-1:0] skid_q, skid_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          accept_s;
  logic          xfer_s;

  assign accept_s    = in_valid & in_ready_q;
  assign xfer_s      = out_valid_q & out_ready;
  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_payload = main_q;

  // Next-state and datapath steering for the EMPTY/ONE/TWO buffer.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          main_d  = in_payload;
          state_d = ST_ONE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && xfer_s) begin
          main_d  = in_payload;
          state_d = ST_ONE;
        end else if (accept_s) begin
          skid_d  = in_payload;
          state_d = ST_TWO;
        end else if (xfer_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only the drain can happen.
        if (xfer_s) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end else begin
          state_d = ST_TWO;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // Buffer registers; reset discards anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= {PW{1'b0}};
      skid_q      <= {PW{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: rtl/imm_narrow_unit.sv
// Signed narrowing stage: IN_W value -> OUT_W immediate field plus fit flag,
// buffered through a skid buffer, with a saturating range-violation counter.
// The narrowing function is elaborated at the package widths.
module imm_narrow_unit
  import imm_narrow_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_fit,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_count
);

  narrow_t          nar_s;
  logic [OUT_W:0]   out_payload_s;
  logic             acc_nonfit_s;
  logic [CNT_W-1:0] ovf_q, ovf_d;

  assign nar_s = narrow(in_data, sat_en);

  narrow_skid_buf #(.PW(OUT_W + 1)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_payload (nar_s),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_payload(out_payload_s)
  );

  assign out_data  = out_payload_s[OUT_W-1:0];
  assign out_fit   = out_payload_s[OUT_W];
  assign ovf_count = ovf_q;

  assign acc_nonfit_s = in_valid & in_ready & ~nar_s.fit;

  // Overflow counter: clear wins, but a same-cycle violation still counts.
  always_comb begin
    if (clr_count) begin
      ovf_d = acc_nonfit_s ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
    end else if (acc_nonfit_s && (ovf_q != {CNT_W{1'b1}})) begin
      ovf_d = ovf_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= {CNT_W{1'b0}};
    end else begin
      ovf_q <= ovf_d;
    end
  end

endmodule
